// File: rtl/fpga_gpio_bank.sv
// fpga_gpio_bank: parametrised GPIO bank with direction/output registers,
// input synchronisers, edge-detect sticky interrupts and a one-cycle
// mem-style register port.
// Optional per-channel debounce is enabled with GPIO_DEBOUNCE_EN.
module fpga_gpio_bank #(
   parameter int NUM_GPIO    = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CNT_W   = 16,
   parameter int ADDR_W      = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [3:0]          be_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [31:0]         wdata_i,
   output logic                rvalid_o,
   output logic [31:0]         rdata_o,
   input  logic [NUM_GPIO-1:0] gpio_in_i,
   output logic [NUM_GPIO-1:0] gpio_out_o,
   output logic [NUM_GPIO-1:0] gpio_oe_o,
   output logic                irq_o
);

   typedef logic [NUM_GPIO-1:0] vec_t;

   localparam int unsigned REG_DIR     = 0;
   localparam int unsigned REG_OUT     = 1;
   localparam int unsigned REG_IN      = 2;
   localparam int unsigned REG_RISE_EN = 3;
   localparam int unsigned REG_FALL_EN = 4;
   localparam int unsigned REG_PEND    = 5;
   localparam int unsigned REG_DEB     = 6;
   localparam int unsigned REG_OUT_TGL = 7;

   vec_t dir_q, dir_d;
   vec_t out_q, out_d;
   vec_t rise_en_q, rise_en_d;
   vec_t fall_en_q, fall_en_d;
   vec_t pend_q, pend_d;
   vec_t stable_q, stable_d;
   vec_t stable_dly_q, stable_dly_d;
   vec_t sync_q [SYNC_STAGES];
   vec_t sync_d [SYNC_STAGES];
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;

   vec_t        sync_w;
   vec_t        rise, fall;
   vec_t        wd, wmask, pend_clr;
   logic [31:0] bmask;
   logic [31:0] word_idx;
   logic        wr;

`ifdef GPIO_DEBOUNCE_EN
   logic [DEB_CNT_W-1:0] deb_limit_q, deb_limit_d;
   logic [DEB_CNT_W-1:0] cnt_q [NUM_GPIO];
   logic [DEB_CNT_W-1:0] cnt_d [NUM_GPIO];
`else
   localparam int unsigned UNUSED_DEB_W = DEB_CNT_W;
`endif

   logic unused_bits;
   assign unused_bits = ^{addr_i[1:0], wdata_i, bmask};

   // Decode of the register port: byte-lane masks and word index
   always_comb begin
      bmask    = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
      wmask    = bmask[NUM_GPIO-1:0];
      wd       = wdata_i[NUM_GPIO-1:0];
      word_idx = 32'(addr_i >> 2);
      wr       = req_i & we_i;
   end

   // Register writes, sticky pending bits (set wins over W1C) and read mux
   always_comb begin
      dir_d     = dir_q;
      out_d     = out_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      pend_clr  = '0;
      rdata_d   = '0;
      rvalid_d  = req_i;
`ifdef GPIO_DEBOUNCE_EN
      deb_limit_d = deb_limit_q;
`endif
      if (wr) begin
         case (word_idx)
            REG_DIR:     dir_d     = (dir_q & ~wmask) | (wd & wmask);
            REG_OUT:     out_d     = (out_q & ~wmask) | (wd & wmask);
            REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | (wd & wmask);
            REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | (wd & wmask);
            REG_PEND:    pend_clr  = wd & wmask;
`ifdef GPIO_DEBOUNCE_EN
            REG_DEB:     deb_limit_d = (deb_limit_q & ~bmask[DEB_CNT_W-1:0])
                                     | (wdata_i[DEB_CNT_W-1:0] & bmask[DEB_CNT_W-1:0]);
`endif
            REG_OUT_TGL: out_d     = out_q ^ (wd & wmask);
            default: ;
         endcase
      end else if (req_i) begin
         case (word_idx)
            REG_DIR:     rdata_d = 32'(dir_q);
            REG_OUT:     rdata_d = 32'(out_q);
            REG_IN:      rdata_d = 32'(stable_q);
            REG_RISE_EN: rdata_d = 32'(rise_en_q);
            REG_FALL_EN: rdata_d = 32'(fall_en_q);
            REG_PEND:    rdata_d = 32'(pend_q);
`ifdef GPIO_DEBOUNCE_EN
            REG_DEB:     rdata_d = 32'(deb_limit_q);
`endif
            default:     rdata_d = '0;
         endcase
      end
      pend_d = (pend_q & ~pend_clr) | (rise & rise_en_q) | (fall & fall_en_q);
   end

   // Input synchroniser chain and edge detection on the stable value
   always_comb begin
      sync_d[0] = gpio_in_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      sync_w       = sync_q[SYNC_STAGES-1];
      stable_dly_d = stable_q;
      rise         = stable_q & ~stable_dly_q;
      fall         = ~stable_q & stable_dly_q;
   end

`ifdef GPIO_DEBOUNCE_EN
   // Debounce: count cycles of disagreement; any agreement restarts the count
   always_comb begin
      stable_d = stable_q;
      for (int unsigned i = 0; i < NUM_GPIO; i++) begin
         cnt_d[i] = '0;
         if (sync_w[i] != stable_q[i]) begin
            if (cnt_q[i] == deb_limit_q) begin
               stable_d[i] = sync_w[i];
            end else if (cnt_q[i] == '1) begin
               cnt_d[i] = cnt_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DEB_CNT_W'(1);
            end
         end
      end
   end
`else
   // No debounce: stable value follows the synchroniser output
   always_comb begin
      stable_d = sync_w;
   end
`endif

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dir_q        <= '0;
         out_q        <= '0;
         rise_en_q    <= '0;
         fall_en_q    <= '0;
         pend_q       <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         sync_q       <= '{default: '0};
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
`ifdef GPIO_DEBOUNCE_EN
         deb_limit_q  <= '0;
         cnt_q        <= '{default: '0};
`endif
      end else begin
         dir_q        <= dir_d;
         out_q        <= out_d;
         rise_en_q    <= rise_en_d;
         fall_en_q    <= fall_en_d;
         pend_q       <= pend_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         sync_q       <= sync_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
`ifdef GPIO_DEBOUNCE_EN
         deb_limit_q  <= deb_limit_d;
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign rvalid_o   = rvalid_q;
   assign rdata_o    = rdata_q;
   assign gpio_oe_o  = dir_q;
   assign gpio_out_o = out_q;
   assign irq_o      = |pend_q;

endmodule

// File: tb/tb_fpga_gpio_bank.sv
// Testbench for fpga_gpio_bank: directed register/pin vectors with a
// scoreboard queue of expected responses popped by a monitor on rvalid_o.
module tb_fpga_gpio_bank;

   localparam int SS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0, req8 = 1'b0, we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [7:0]  addr = 8'h00;
   logic [31:0] wdata = '0;
   logic [31:0] gpio_in = '0;
   logic [7:0]  gpio_in8 = '0;

   logic        rvalid, irq, rvalid8, irq8;
   logic [31:0] rdata, rdata8, gpio_out, gpio_oe;
   logic [7:0]  gpio_out8, gpio_oe8;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] q  [$];
   logic [31:0] q8 [$];

   always #5 clk = ~clk;

   fpga_gpio_bank #(.NUM_GPIO(32), .SYNC_STAGES(SS), .DEB_CNT_W(16), .ADDR_W(8)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .gpio_in_i(gpio_in),
      .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe), .irq_o(irq));

   fpga_gpio_bank #(.NUM_GPIO(8), .SYNC_STAGES(SS), .DEB_CNT_W(16), .ADDR_W(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .req_i(req8), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .rvalid_o(rvalid8), .rdata_o(rdata8), .gpio_in_i(gpio_in8),
      .gpio_out_o(gpio_out8), .gpio_oe_o(gpio_oe8), .irq_o(irq8));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Pops one expectation per response of each DUT; idle rdata must be 0
   task automatic monitor();
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rvalid) begin
            if (q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
            else begin e = q.pop_front(); check("rdata", rdata, e); end
         end else check("idle_rdata", rdata, 32'd0);
         if (rvalid8) begin
            if (q8.size() == 0) check("unexpected_rvalid8", 32'd1, 32'd0);
            else begin e = q8.pop_front(); check("rdata8", rdata8, e); end
         end
      end
   endtask

   // One access issued at a negedge, sampled at the next posedge
   task automatic acc(input bit t8, input bit w, input logic [7:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp);
      we = w; addr = a; be = b; wdata = d;
      if (t8) begin req8 = 1'b1; q8.push_back(w ? 32'd0 : exp); end
      else    begin req  = 1'b1; q.push_back(w ? 32'd0 : exp); end
      @(negedge clk);
      req = 1'b0; req8 = 1'b0;
   endtask

   initial begin
      fork monitor(); join_none
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Junk state, then a reset pulse that also swallows an access
      acc(0, 1, 8'h00, 4'hF, 32'hFFFF_FFFF, 0);
      acc(0, 1, 8'h04, 4'hF, 32'hFFFF_FFFF, 0);
      acc(0, 1, 8'h0C, 4'hF, 32'hFFFF_FFFF, 0);
      acc(0, 1, 8'h10, 4'hF, 32'hFFFF_FFFF, 0);
      gpio_in = 32'h5A5A_5A5A;
      repeat (6) @(negedge clk);
      gpio_in = 32'hA5A5_A5A5;
      repeat (6) @(negedge clk);
      check("junk_irq", {31'd0, irq}, 32'd1);
      check("junk_oe", gpio_oe, 32'hFFFF_FFFF);
      rst = 1'b1; req = 1'b1; we = 1'b1; addr = 8'h14; be = 4'hF;
      wdata = 32'hFFFF_FFFF; gpio_in = '0;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_oe", gpio_oe, 32'd0);
      check("rst_out", gpio_out, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      for (int i = 0; i < 8; i++) acc(0, 0, 8'(i * 4), 4'hF, 0, 32'd0);

      // DIR/OUT/OUT_TGL with byte enables
      acc(0, 1, 8'h00, 4'hF, 32'h0000_00FF, 0);
      acc(0, 1, 8'h04, 4'h1, 32'hFFFF_FFA5, 0);
      acc(0, 1, 8'h1C, 4'hF, 32'h0000_000F, 0);
      acc(0, 0, 8'h04, 4'hF, 0, 32'h0000_00AA);
      acc(0, 0, 8'h1C, 4'hF, 0, 32'h0000_0000);
      acc(0, 0, 8'h00, 4'hF, 0, 32'h0000_00FF);
      check("pin_oe", gpio_oe, 32'h0000_00FF);
      check("pin_out", gpio_out, 32'h0000_00AA);
      acc(0, 1, 8'h00, 4'h6, 32'h1234_5678, 0);
      acc(0, 0, 8'h00, 4'hF, 0, 32'h0034_56FF);
      acc(0, 0, 8'h40, 4'hF, 0, 32'h0000_0000);

      // Rising edge on ch3 sets PEND after SS+2 cycles; W1C clears it
      acc(0, 1, 8'h0C, 4'hF, 32'h0000_0008, 0);
      gpio_in[3] = 1'b1;
      repeat (SS + 1) @(negedge clk);
      check("irq_before", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_rise", {31'd0, irq}, 32'd1);
      acc(0, 0, 8'h14, 4'hF, 0, 32'h0000_0008);
      acc(0, 0, 8'h08, 4'hF, 0, 32'h0000_0008);
      acc(0, 1, 8'h14, 4'hF, 32'h0000_0008, 0);
      check("irq_w1c", {31'd0, irq}, 32'd0);
      acc(0, 0, 8'h14, 4'hF, 0, 32'h0000_0000);

      // Falling edge while FALL_EN off, then enabling must not retro-trigger
      gpio_in[3] = 1'b0;
      repeat (8) @(negedge clk);
      check("irq_fall_dis", {31'd0, irq}, 32'd0);
      acc(0, 1, 8'h10, 4'hF, 32'h0000_0008, 0);
      repeat (4) @(negedge clk);
      check("irq_no_retro", {31'd0, irq}, 32'd0);

      // W1C in the same cycle as a new rise: set wins
      gpio_in[3] = 1'b1;
      repeat (SS + 1) @(negedge clk);
      acc(0, 1, 8'h14, 4'hF, 32'h0000_0008, 0);
      check("irq_set_wins", {31'd0, irq}, 32'd1);
      acc(0, 0, 8'h14, 4'hF, 0, 32'h0000_0008);
      acc(0, 1, 8'h14, 4'hF, 32'h0000_0008, 0);
      acc(0, 0, 8'h14, 4'hF, 0, 32'h0000_0000);

`ifdef GPIO_DEBOUNCE_EN
      acc(0, 1, 8'h18, 4'hF, 32'h0000_000A, 0);
      acc(0, 0, 8'h18, 4'hF, 0, 32'h0000_000A);
      acc(0, 1, 8'h0C, 4'hF, 32'h0000_0009, 0);
      gpio_in[0] = 1'b1;
      repeat (5) @(negedge clk);
      gpio_in[0] = 1'b0;
      repeat (20) @(negedge clk);
      acc(0, 0, 8'h08, 4'hF, 0, 32'h0000_0008);
      acc(0, 0, 8'h14, 4'hF, 0, 32'h0000_0000);
      gpio_in[0] = 1'b1;
      repeat (12) @(negedge clk);
      acc(0, 0, 8'h08, 4'hF, 0, 32'h0000_0008);
      acc(0, 0, 8'h08, 4'hF, 0, 32'h0000_0009);
      @(negedge clk);
      gpio_in[0] = 1'b0;
      repeat (25) @(negedge clk);
      acc(0, 0, 8'h14, 4'hF, 0, 32'h0000_0001);
      acc(0, 0, 8'h08, 4'hF, 0, 32'h0000_0008);
`else
      acc(0, 1, 8'h18, 4'hF, 32'h0000_000A, 0);
      acc(0, 0, 8'h18, 4'hF, 0, 32'h0000_0000);
`endif

      // NUM_GPIO=8: upper register bits read 0; unmapped address reads 0
      acc(1, 1, 8'h00, 4'hF, 32'hFFFF_FFFF, 0);
      acc(1, 0, 8'h00, 4'hF, 0, 32'h0000_00FF);
      acc(1, 0, 8'h40, 4'hF, 0, 32'h0000_0000);
      check("oe8", {24'd0, gpio_oe8}, 32'h0000_00FF);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(q.size() + q8.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
